// File: rtl/full_subtractor_if.sv
// Operand/result bundle for the full subtractor: the master drives x, y and Bin,
// the slave returns the combinational and registered difference/borrow.
interface full_subtractor_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             Bin;
  logic [WIDTH-1:0] sub;
  logic             Bout;
  logic [WIDTH-1:0] sub_q;
  logic             bout_q;

  modport master (
    output x, y, Bin,
    input  sub, Bout, sub_q, bout_q
  );

  modport slave (
    input  x, y, Bin,
    output sub, Bout, sub_q, bout_q
  );
endinterface

// File: rtl/full_subtractor.sv
// Ripple-borrow full subtractor: x - y - Bin as a chain of 1-bit cells, with the
// combinational result also captured in a one-cycle registered output stage.
module full_subtractor #(
  parameter int WIDTH = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  full_subtractor_if.slave  bus
);

  logic [WIDTH:0]   w_b;
  logic [WIDTH-1:0] w_sub;
  logic [WIDTH-1:0] r_sub_p1;
  logic             r_bout_p1;

  assign w_b[0] = bus.Bin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    assign w_sub[i]  = bus.x[i] ^ bus.y[i] ^ w_b[i];
    assign w_b[i+1]  = (~bus.x[i] & bus.y[i]) | (~(bus.x[i] ^ bus.y[i]) & w_b[i]);
  end

  assign bus.sub  = w_sub;
  assign bus.Bout = w_b[WIDTH];

  // p0 -> p1: the registered copy clears asynchronously so it never holds X after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sub_p1  <= '0;
      r_bout_p1 <= 1'b0;
    end else begin
      r_sub_p1  <= w_sub;
      r_bout_p1 <= w_b[WIDTH];
    end
  end

  assign bus.sub_q  = r_sub_p1;
  assign bus.bout_q = r_bout_p1;

endmodule

// File: tb/tb_full_subtractor.sv
// Bench for full_subtractor: WIDTH=8 and WIDTH=1 instances, arithmetic reference model,
// scoreboard queue for the registered path of the 8-bit instance.
module tb_full_subtractor;

  logic clk;
  logic rst_n;

  full_subtractor_if #(.WIDTH(8)) if8();
  full_subtractor_if #(.WIDTH(1)) if1();

  full_subtractor #(.WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));
  full_subtractor #(.WIDTH(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  int n_checks = 0;
  int n_errors = 0;

  logic [8:0] exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Returns {Bout, sub} for an 8-bit subtraction from plain signed arithmetic.
  function automatic logic [8:0] model8(input logic [7:0] a, input logic [7:0] b, input logic bi);
    int d;
    logic [8:0] r;
    d = int'(a) - int'(b) - int'(bi);
    r[7:0] = d[7:0];
    r[8]   = (d < 0);
    return r;
  endfunction

  function automatic logic [1:0] model1(input logic a, input logic b, input logic bi);
    int d;
    logic [1:0] r;
    d = int'(a) - int'(b) - int'(bi);
    r[0] = d[0];
    r[1] = (d < 0);
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic comb_checks();
    check("comb8", {23'd0, if8.Bout, if8.sub}, {23'd0, model8(if8.x, if8.y, if8.Bin)});
    check("comb1", {30'd0, if1.Bout, if1.sub}, {30'd0, model1(if1.x[0], if1.y[0], if1.Bin)});
  endtask

  // Drive both instances on the falling edge; expected registered value goes to the scoreboard.
  task automatic step(input logic [7:0] a8, input logic [7:0] b8, input logic bi8,
                      input logic a1, input logic b1, input logic bi1);
    @(negedge clk);
    if8.x = a8; if8.y = b8; if8.Bin = bi8;
    if1.x = a1; if1.y = b1; if1.Bin = bi1;
    if (rst_n) exp_q.push_back(model8(a8, b8, bi8));
    #1;
    comb_checks();
  endtask

  // Monitor: every clock out of reset, the registered outputs must show what was issued last cycle.
  always @(posedge clk) begin
    #1;
    if (rst_n && exp_q.size() > 0) begin
      logic [8:0] e;
      e = exp_q.pop_front();
      check("reg8", {23'd0, if8.bout_q, if8.sub_q}, {23'd0, e});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b1;
    if8.x = '0; if8.y = '0; if8.Bin = 1'b0;
    if1.x = '0; if1.y = '0; if1.Bin = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_sub_q8",  {24'd0, if8.sub_q}, 32'd0);
    check("rst_bout_q8", {31'd0, if8.bout_q}, 32'd0);
    check("rst_sub_q1",  {31'd0, if1.sub_q}, 32'd0);
    check("rst_bout_q1", {31'd0, if1.bout_q}, 32'd0);

    // Exhaustive 1-bit sweep while held in reset: combinational path must ignore reset.
    for (int v = 0; v < 8; v++) begin
      logic [2:0] bits;
      logic [1:0] tt;
      bits = v[2:0];
      if1.x = bits[2]; if1.y = bits[1]; if1.Bin = bits[0];
      #1;
      case (bits)
        3'b000: tt = 2'b00; 3'b001: tt = 2'b11; 3'b010: tt = 2'b11; 3'b011: tt = 2'b01;
        3'b100: tt = 2'b10; 3'b101: tt = 2'b00; 3'b110: tt = 2'b00; default: tt = 2'b11;
      endcase
      check("tt1", {30'd0, if1.sub, if1.Bout}, {30'd0, tt});
    end

    // Toggle stimulus: x and Bin every 5 ns, y every 10 ns, starting x=1,y=0,Bin=1.
    if1.x = 1'b1; if1.y = 1'b0; if1.Bin = 1'b1;
    for (int t = 0; t < 20; t++) begin
      #1;
      check("toggle1", {30'd0, if1.Bout, if1.sub}, {30'd0, model1(if1.x[0], if1.y[0], if1.Bin)});
      #4;
      if1.x = ~if1.x; if1.Bin = ~if1.Bin;
      if (t % 2 == 1) if1.y = ~if1.y;
    end

    @(negedge clk);
    rst_n = 1'b1;

    // WIDTH=8 boundaries with explicit expectations.
    step(8'h00, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1);
    check("b8_wrap", {23'd0, if8.Bout, if8.sub}, {23'd0, 9'h1FF});
    step(8'hFF, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
    check("b8_ff", {23'd0, if8.Bout, if8.sub}, {23'd0, 9'h0FE});
    step(8'h80, 8'h80, 1'b1, 1'b0, 1'b0, 1'b1);
    check("b8_80", {23'd0, if8.Bout, if8.sub}, {23'd0, 9'h1FF});

    // Registered path on the 1-bit cell.
    step(8'h12, 8'h34, 1'b0, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    check("reg1_a", {30'd0, if1.sub_q, if1.bout_q}, {30'd0, 2'b11});
    step(8'h55, 8'h55, 1'b0, 1'b1, 1'b1, 1'b0);
    @(posedge clk); #1;
    check("reg1_b", {30'd0, if1.sub_q, if1.bout_q}, {30'd0, 2'b00});
    step(8'h00, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    check("reg1_c", {30'd0, if1.sub_q, if1.bout_q}, {30'd0, 2'b11});

    // Asynchronous reset between edges.
    #1 rst_n = 1'b0;
    #1;
    check("arst_sub_q1",  {31'd0, if1.sub_q}, 32'd0);
    check("arst_bout_q1", {31'd0, if1.bout_q}, 32'd0);
    check("arst_sub_q8",  {24'd0, if8.sub_q}, 32'd0);
    check("arst_bout_q8", {31'd0, if8.bout_q}, 32'd0);
    check("arst_comb1", {30'd0, if1.sub, if1.Bout}, {30'd0, 2'b11});
    check("arst_comb8", {23'd0, if8.Bout, if8.sub}, {23'd0, 9'h100});
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;

    // Random regression.
    for (int n = 0; n < 1200; n++) begin
      logic [7:0] ra, rb;
      logic [2:0] r1;
      ra = 8'($urandom);
      rb = 8'($urandom);
      r1 = 3'($urandom);
      step(ra, rb, 1'($urandom), r1[2], r1[1], r1[0]);
    end

    repeat (3) @(negedge clk);
    check("sb_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
